// File: rtl/debug_autobaud_pkg.sv
// Shared state encodings and width helper for the debug auto-baud detector.
package debug_autobaud_pkg;

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Width of a channel select where 0 means "no channel".
   function automatic int sel_width(input int num_rx);
      return $clog2(num_rx + 1);
   endfunction

endpackage

// File: rtl/debug_autobaud_edge.sv
// Per-channel RX sampling and edge flag; DEBUG_AUTOBAUD_SYNC_EN adds a 2-flop synchronizer.
module debug_autobaud_edge
   import debug_autobaud_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic rx_i,
   output logic samp_o,
   output logic edge_o
);

   logic samp_q, samp_d;
   logic prev_q, prev_d;

`ifdef DEBUG_AUTOBAUD_SYNC_EN
   logic [1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[0], rx_i};
      samp_d = sync_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end
`else
   always_comb begin
      samp_d = rx_i;
   end
`endif

   always_comb begin
      prev_d = samp_q;
   end

   // Reset to the idle-high UART level so release does not fake an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         samp_q <= samp_d;
         prev_q <= prev_d;
      end
   end

   assign samp_o = samp_q;
   assign edge_o = samp_q ^ prev_q;

endmodule

// File: rtl/debug_autobaud_mc.sv
// Multi-channel auto-baud detector: pulse-width counter, divisor history, match and lock FSM.
// Optional input synchronizer selected with DEBUG_AUTOBAUD_SYNC_EN (see debug_autobaud_edge).
module debug_autobaud_mc
   import debug_autobaud_pkg::*;
#(
   parameter  int NUM_RX    = 3,
   parameter  int CNT_W     = 14,
   parameter  int DIV_W     = 8,
   parameter  int DIV_SHIFT = 5,
   parameter  int MATCH_CNT = 3,
   parameter  int TOL       = 0,
   localparam int SEL_W     = sel_width(NUM_RX)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disabled,
   input  logic              rearm,
   input  logic [NUM_RX-1:0] rx,
   output logic              wr,
   output logic [DIV_W-1:0]  div,
   output logic [SEL_W-1:0]  rx_sel,
   output logic              locked
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [DIV_W:0]   TOL_X   = (DIV_W+1)'(TOL);

   logic [NUM_RX-1:0] samp;
   logic [NUM_RX-1:0] edg;

   for (genvar g = 0; g < NUM_RX; g++) begin : g_chan
      debug_autobaud_edge u_edge (
         .clk    (clk),
         .rst_n  (rst_n),
         .rx_i   (rx[g]),
         .samp_o (samp[g]),
         .edge_o (edg[g])
      );
   end

   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [DIV_W-1:0] hist_q [MATCH_CNT];
   logic [DIV_W-1:0] hist_d [MATCH_CNT];
   logic [SEL_W-1:0] cand_q,   cand_d;
   logic [SEL_W-1:0] rx_sel_q, rx_sel_d;
   logic             wr_q,     wr_d;

   logic             edge_any;
   logic             cnt_sat;
   logic             match;
   logic             cand_line;
   logic             found;
   logic [SEL_W-1:0] cand_new;
   logic [DIV_W-1:0] div_new;
   logic [DIV_W:0]   diff;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      edge_any = |edg;
      cnt_sat  = (cnt_q == CNT_MAX);
      div_new  = cnt_q[DIV_SHIFT +: DIV_W];
      cnt_next = edge_any ? '0 : (cnt_sat ? cnt_q : cnt_q + 1'b1);

      cand_new = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < NUM_RX; i++) begin
         if (edg[i] && !found) begin
            cand_new = SEL_W'(i + 1);
            found    = 1'b1;
         end
      end

      cand_line = 1'b0;
      for (int unsigned i = 0; i < NUM_RX; i++) begin
         if (cand_q == SEL_W'(i + 1)) begin
            cand_line = samp[i];
         end
      end

      // Every entry, including history[0] itself, must be nonzero.
      match = 1'b1;
      diff  = '0;
      for (int unsigned i = 0; i < MATCH_CNT; i++) begin
         if ({1'b0, hist_q[0]} >= {1'b0, hist_q[i]}) begin
            diff = {1'b0, hist_q[0]} - {1'b0, hist_q[i]};
         end else begin
            diff = {1'b0, hist_q[i]} - {1'b0, hist_q[0]};
         end
         if (hist_q[i] == '0 || diff > TOL_X) begin
            match = 1'b0;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hist_d   = hist_q;
      cand_d   = cand_q;
      rx_sel_d = rx_sel_q;
      wr_d     = 1'b0;

      case (state_q)
         ST_HUNT: begin
            cnt_d = cnt_next;
            if (edge_any) begin
               cand_d = cand_new;
               if (!cnt_sat) begin
                  hist_d[0] = div_new;
                  for (int unsigned i = 1; i < MATCH_CNT; i++) begin
                     hist_d[i] = hist_q[i-1];
                  end
               end
               if (disabled) begin
                  rx_sel_d = cand_new;
                  state_d  = ST_DONE;
               end
            end else if (match) begin
               wr_d    = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_next;
            if ((cnt_sat && cand_line) || disabled) begin
               rx_sel_d = cand_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            wr_d = wr_q;
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase

      if (rearm) begin
         state_d  = ST_HUNT;
         cnt_d    = '0;
         hist_d   = '{default: '0};
         cand_d   = '0;
         rx_sel_d = '0;
         wr_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HUNT;
         cnt_q    <= '0;
         hist_q   <= '{default: '0};
         cand_q   <= '0;
         rx_sel_q <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hist_q   <= hist_d;
         cand_q   <= cand_d;
         rx_sel_q <= rx_sel_d;
         wr_q     <= wr_d;
      end
   end

   assign wr     = wr_q;
   assign div    = hist_q[0];
   assign rx_sel = rx_sel_q;
   assign locked = (state_q == ST_DONE);

endmodule
